// File: rtl/apb_fll_cfg_pkg.sv
// -----------------------------------------------------------------------------
// apb_fll_cfg_pkg
//   Shared definitions for the APB-to-FLL configuration bridge:
//   handshake FSM state encoding, APB register index map (PADDR[4:2]),
//   STATUS register bit positions and a small address-decode helper.
// -----------------------------------------------------------------------------
package apb_fll_cfg_pkg;

  typedef enum logic [1:0] {
    FLL_IDLE    = 2'd0,
    FLL_REQ     = 2'd1,
    FLL_ACK_LOW = 2'd2,
    FLL_RESP    = 2'd3
  } fll_cfg_state_e;

  // Register index as decoded from PADDR[4:2]
  localparam logic [2:0] FLL_REG0   = 3'd0;
  localparam logic [2:0] FLL_REG1   = 3'd1;
  localparam logic [2:0] FLL_REG2   = 3'd2;
  localparam logic [2:0] FLL_REG3   = 3'd3;
  localparam logic [2:0] STATUS_IDX = 3'd4;

  // STATUS register bit positions
  localparam int STATUS_LOCK_BIT      = 0;
  localparam int STATUS_TIMEOUT_BIT   = 1;
  localparam int STATUS_LOCK_LOST_BIT = 2;

  // Indices 0..3 are forwarded to the FLL config port
  function automatic logic is_fll_reg(input logic [2:0] idx);
    return (idx[2] == 1'b0);
  endfunction

endpackage

// File: rtl/apb_fll_cfg_bridge_lock_sync.sv
// -----------------------------------------------------------------------------
// fll_lock_sync
//   Two-flop synchroniser bringing the asynchronous FLL lock indication into
//   the clk_i domain. Flops clear to 0 on reset so "locked" is never reported
//   before the FLL actually asserts lock after reset.
// Ports
//   clk_i    in  1  clock
//   rstn_i   in  1  asynchronous active-low reset
//   async_i  in  1  asynchronous lock input
//   sync_o   out 1  synchronised lock
// -----------------------------------------------------------------------------
module fll_lock_sync (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic async_i,
  output logic sync_o
);

  localparam int STAGES = 2;

  logic [STAGES-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stage_q[0] <= 1'b0;
    end else begin
      stage_q[0] <= async_i;
    end
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        stage_q[gi] <= 1'b0;
      end else begin
        stage_q[gi] <= stage_q[gi-1];
      end
    end
  end

  assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/apb_fll_cfg_bridge.sv
// -----------------------------------------------------------------------------
// apb_fll_cfg_bridge
//   APB slave in front of the clock generator's FLL configuration port.
//   Accesses to PADDR[4:2]=0..3 become a 4-phase req/ack handshake on the FLL
//   port with PREADY held low until it completes (or a timeout aborts it).
//   Index 4 is a local STATUS register, 5..7 answer with PSLVERR.
// Ports
//   clk_i, rstn_i             clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE -> APB request
//   PRDATA/PREADY/PSLVERR     <- APB response
//   fll_req_o/wrn_o/add_o/data_o -> FLL config request (wrn: 0=write, 1=read)
//   fll_ack_i/r_data_i        <- FLL acknowledge and read data
//   fll_lock_i                <- FLL lock (asynchronous)
//   irq_o                     lock-lost interrupt, only with FLL_LOCK_IRQ_EN
// Build option
//   FLL_LOCK_IRQ_EN: adds the LOCK_LOST sticky (STATUS[2]) and irq_o.
// -----------------------------------------------------------------------------
module apb_fll_cfg_bridge
  import apb_fll_cfg_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      fll_req_o,
  output logic                      fll_wrn_o,
  output logic [1:0]                fll_add_o,
  output logic [31:0]               fll_data_o,
  input  logic                      fll_ack_i,
  input  logic [31:0]               fll_r_data_i,
  input  logic                      fll_lock_i
`ifdef FLL_LOCK_IRQ_EN
  ,
  output logic                      irq_o
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  fll_cfg_state_e    state_q, state_d;
  logic              req_q, req_d;
  logic              wrn_q, wrn_d;
  logic [1:0]        add_q, add_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              lock_sync;
  logic              lock_lost;
  logic [2:0]        reg_idx;
  logic              access;
  logic              status_wr;
  logic [31:0]       status_rd;
  logic              unused_paddr;

  assign reg_idx      = PADDR[4:2];
  assign access       = PSEL & PENABLE;
  // STATUS is only served while no FLL handshake is in flight
  assign status_wr    = access & PWRITE & (state_q == FLL_IDLE) & (reg_idx == STATUS_IDX);
  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  fll_lock_sync u_lock_sync (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .async_i (fll_lock_i),
    .sync_o  (lock_sync)
  );

  always_comb begin
    status_rd = 32'd0;
    status_rd[STATUS_LOCK_BIT]      = lock_sync;
    status_rd[STATUS_TIMEOUT_BIT]   = timeout_q;
    status_rd[STATUS_LOCK_LOST_BIT] = lock_lost;
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wrn_d     = wrn_q;
    add_d     = add_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    PREADY    = 1'b0;
    PRDATA    = 32'd0;
    PSLVERR   = 1'b0;

    if (status_wr && PWDATA[STATUS_TIMEOUT_BIT]) begin
      timeout_d = 1'b0;
    end

    unique case (state_q)
      FLL_IDLE: begin
        if (access) begin
          if (is_fll_reg(reg_idx)) begin
            // Request fields are captured here and held until the next IDLE
            add_d   = PADDR[3:2];
            wrn_d   = ~PWRITE;
            wdata_d = PWDATA;
            rdata_d = 32'd0;
            err_d   = 1'b0;
            cnt_d   = '0;
            req_d   = 1'b1;
            state_d = FLL_REQ;
          end else if (reg_idx == STATUS_IDX) begin
            PREADY = 1'b1;
            PRDATA = PWRITE ? 32'd0 : status_rd;
          end else begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
          end
        end
      end

      FLL_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (fll_ack_i) begin
          rdata_d = wrn_q ? fll_r_data_i : 32'd0;
          req_d   = 1'b0;
          state_d = FLL_ACK_LOW;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          req_d     = 1'b0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          rdata_d   = 32'd0;
          state_d   = FLL_RESP;
        end
      end

      FLL_ACK_LOW: begin
        cnt_d = cnt_q + 1'b1;
        if (!fll_ack_i) begin
          state_d = FLL_RESP;
        end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
          // ack stuck high: abort and discard whatever was latched
          err_d     = 1'b1;
          timeout_d = 1'b1;
          rdata_d   = 32'd0;
          state_d   = FLL_RESP;
        end
      end

      FLL_RESP: begin
        // Completes even if PSEL was dropped mid-transfer
        PREADY  = 1'b1;
        PRDATA  = rdata_q;
        PSLVERR = err_q;
        state_d = FLL_IDLE;
      end

      default: state_d = FLL_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= FLL_IDLE;
      req_q     <= 1'b0;
      wrn_q     <= 1'b0;
      add_q     <= 2'd0;
      wdata_q   <= 32'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wrn_q     <= wrn_d;
      add_q     <= add_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign fll_req_o  = req_q;
  assign fll_wrn_o  = wrn_q;
  assign fll_add_o  = add_q;
  assign fll_data_o = wdata_q;

`ifdef FLL_LOCK_IRQ_EN
  logic lock_prev_q;
  logic lock_lost_q, lock_lost_d;

  // A falling synchronised lock sets the sticky; set overrides a same-cycle clear
  always_comb begin
    lock_lost_d = lock_lost_q;
    if (status_wr && PWDATA[STATUS_LOCK_LOST_BIT]) begin
      lock_lost_d = 1'b0;
    end
    if (lock_prev_q && !lock_sync) begin
      lock_lost_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_prev_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_prev_q <= lock_sync;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign lock_lost = lock_lost_q;
  assign irq_o     = lock_lost_q;
`else
  assign lock_lost = 1'b0;
`endif

endmodule

// File: tb/tb_apb_fll_cfg_bridge.sv
module tb_apb_fll_cfg_bridge;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        fll_req_o, fll_wrn_o;
  logic [1:0]  fll_add_o;
  logic [31:0] fll_data_o;
  logic        fll_ack_i;
  logic [31:0] fll_r_data_i;
  logic        fll_lock_i;
`ifdef FLL_LOCK_IRQ_EN
  logic        irq_o;
`endif

  apb_fll_cfg_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .fll_req_o(fll_req_o), .fll_wrn_o(fll_wrn_o), .fll_add_o(fll_add_o),
    .fll_data_o(fll_data_o), .fll_ack_i(fll_ack_i), .fll_r_data_i(fll_r_data_i),
    .fll_lock_i(fll_lock_i)
`ifdef FLL_LOCK_IRQ_EN
    , .irq_o(irq_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", name, act, exp);
    end
  endtask

  // ---------------- FLL responder: 0 = ack looped from req, >0 = ack after N cycles, <0 = never
  int          ack_mode = 0;
  int          ack_wait = 0;
  logic        ack_reg  = 1'b0;
  logic [31:0] fll_mem [4];

  assign fll_ack_i    = (ack_mode == 0) ? fll_req_o : ack_reg;
  assign fll_r_data_i = fll_ack_i ? fll_mem[fll_add_o] : 32'hBAD0_BAD0;

  always @(posedge clk_i) begin
    if (fll_req_o && fll_ack_i && !fll_wrn_o) fll_mem[fll_add_o] <= fll_data_o;
    if (ack_mode > 0 && fll_req_o) begin
      if (!ack_reg) begin
        ack_wait <= ack_wait + 1;
        if (ack_wait + 1 >= ack_mode) ack_reg <= 1'b1;
      end
    end else begin
      ack_reg  <= 1'b0;
      ack_wait <= 0;
    end
  end

  // ---------------- reference model state
  logic [31:0] ref_regs [4];
  logic        timeout_m = 1'b0;
  logic        lost_m = 1'b0;
  logic        exp_lock = 1'b0;
  logic        drop_pending = 1'b0;

  // expected FLL request while one is outstanding
  logic        fll_outstanding = 1'b0;
  logic        exp_wrn = 1'b0;
  logic [1:0]  exp_add = 2'd0;
  logic [31:0] exp_data = 32'd0;

  // observed request history
  int          req_hi_total = 0;
  logic        last_wrn = 1'b0;
  logic [1:0]  last_add = 2'd0;
  logic [31:0] last_data = 32'd0;

  // ---------------- per-cycle compare process
  always @(negedge clk_i) begin
    if (!rstn_i) begin
      chk_b("req_in_reset", fll_req_o, 1'b0);
      chk_b("pready_in_reset", PREADY, 1'b0);
    end else if (fll_req_o) begin
      req_hi_total <= req_hi_total + 1;
      last_wrn     <= fll_wrn_o;
      last_add     <= fll_add_o;
      last_data    <= fll_data_o;
      chk_b("req_expected", fll_outstanding, 1'b1);
      if (fll_outstanding) begin
        chk_w("fll_add", 32'(fll_add_o), 32'(exp_add));
        chk_b("fll_wrn", fll_wrn_o, exp_wrn);
        chk_w("fll_data", fll_data_o, exp_data);
      end
    end
  end

  // ---------------- APB driver; call and return at posedge+1
  task automatic apb_xfer(input logic [2:0] idx, input logic wr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
    logic done;
    PADDR   = {7'($urandom_range(0, 127)), idx, 2'b00};
    PWRITE  = wr;
    PWDATA  = wd;
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    @(posedge clk_i); #1;
    PENABLE = 1'b1;
    lat  = 0;
    rd   = 32'd0;
    er   = 1'b0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk_i);
      lat++;
      if (PREADY) begin
        rd   = PRDATA;
        er   = PSLVERR;
        done = 1'b1;
      end else if (lat >= 200) begin
        chk_b("pready_bound", 1'b0, 1'b1);
        done = 1'b1;
      end
    end
    @(posedge clk_i); #1;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    $display("txn paddr=%h wr=%0d wdata=%h rdata=%h err=%0d lat=%0d ack_mode=%0d",
             PADDR, wr, wd, rd, er, lat, ack_mode);
  endtask

  // ---------------- transaction with model-derived expectations
  task automatic do_txn(input logic [2:0] idx, input logic wr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    logic [31:0] e_rd;
    logic        e_er;
    int          e_lat;
    int          e_pulse;
    int          h0;
    logic        timed_out;
    h0 = req_hi_total;
    if (idx < 3'd4) begin
      timed_out       = (ack_mode < 0);
      exp_add         = idx[1:0];
      exp_wrn         = ~wr;
      exp_data        = wd;
      fll_outstanding = 1'b1;
      e_er  = timed_out;
      e_rd  = (wr || timed_out) ? 32'd0 : ref_regs[idx[1:0]];
      e_lat = timed_out ? TO + 2 : (ack_mode == 0 ? 4 : ack_mode + 5);
      e_pulse = timed_out ? TO : (ack_mode == 0 ? 1 : ack_mode + 1);
      apb_xfer(idx, wr, wd, rd, er, lat);
      fll_outstanding = 1'b0;
      if (timed_out) timeout_m = 1'b1;
      else if (wr) ref_regs[idx[1:0]] = wd;
    end else if (idx == 3'd4) begin
      e_er  = 1'b0;
      e_rd  = wr ? 32'd0 : {29'd0, lost_m, timeout_m, exp_lock};
      e_lat = 1;
      e_pulse = 0;
      apb_xfer(idx, wr, wd, rd, er, lat);
      if (wr) begin
        if (wd[1]) timeout_m = 1'b0;
`ifdef FLL_LOCK_IRQ_EN
        if (wd[2]) lost_m = drop_pending;
`endif
      end
    end else begin
      e_er  = 1'b1;
      e_rd  = 32'd0;
      e_lat = 1;
      e_pulse = 0;
      apb_xfer(idx, wr, wd, rd, er, lat);
    end
    chk_w("prdata", rd, e_rd);
    chk_b("pslverr", er, e_er);
    chk_w("latency", 32'(lat), 32'(e_lat));
    chk_w("req_pulse_cycles", 32'(req_hi_total - h0), 32'(e_pulse));
`ifdef FLL_LOCK_IRQ_EN
    chk_b("irq", irq_o, lost_m);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    for (int i = 0; i < 4; i++) begin
      logic [31:0] v;
      v = $urandom;
      fll_mem[i] <= v;
      ref_regs[i] = v;
    end
    PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    fll_lock_i = 1'b0;
    rstn_i = 1'b1;
    #1 rstn_i = 1'b0;
    #1;
    // reset state
    chk_b("rst_req", fll_req_o, 1'b0);
    chk_b("rst_wrn", fll_wrn_o, 1'b0);
    chk_w("rst_add", 32'(fll_add_o), 32'd0);
    chk_w("rst_data", fll_data_o, 32'd0);
    chk_b("rst_pready", PREADY, 1'b0);
    chk_b("rst_pslverr", PSLVERR, 1'b0);
    chk_w("rst_prdata", PRDATA, 32'd0);
`ifdef FLL_LOCK_IRQ_EN
    chk_b("rst_irq", irq_o, 1'b0);
`endif
    repeat (3) @(posedge clk_i);
    #2 rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // 1: write with looped-back ack
    ack_mode = 0;
    do_txn(3'd1, 1'b1, 32'hDEAD_BEEF, rd, er, lat);
    chk_w("t1_lat", 32'(lat), 32'd4);
    chk_b("t1_err", er, 1'b0);
    chk_w("t1_add", 32'(last_add), 32'd1);
    chk_b("t1_wrn", last_wrn, 1'b0);
    chk_w("t1_data", last_data, 32'hDEAD_BEEF);

    // 2: read with ack delayed by 5 cycles
    do_txn(3'd3, 1'b1, 32'h1234_5678, rd, er, lat);
    ack_mode = 5;
    do_txn(3'd3, 1'b0, 32'h0, rd, er, lat);
    chk_w("t2_rdata", rd, 32'h1234_5678);
    chk_w("t2_add", 32'(last_add), 32'd3);
    chk_b("t2_wrn", last_wrn, 1'b1);

    // 3: ack never comes
    ack_mode = -1;
    do_txn(3'd2, 1'b1, 32'hCAFE_0001, rd, er, lat);
    chk_b("t3_err", er, 1'b1);
    chk_w("t3_lat", 32'(lat), 32'(TO + 2));
    ack_mode = 0;
    do_txn(3'd4, 1'b0, 32'h0, rd, er, lat);
    chk_w("t3_status", rd, 32'h2);
    do_txn(3'd4, 1'b1, 32'h2, rd, er, lat);
    do_txn(3'd4, 1'b0, 32'h0, rd, er, lat);
    chk_w("t3_status_cleared", rd, 32'h0);

    // 4: reserved index
    do_txn(3'd5, 1'b0, 32'h0, rd, er, lat);
    chk_w("t4_rdata", rd, 32'h0);
    chk_b("t4_err", er, 1'b1);
    chk_w("t4_lat", 32'(lat), 32'd1);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      ack_mode = int'($urandom_range(0, 6));
      do_txn(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom, rd, er, lat);
    end
    ack_mode = 0;

    // 5: lock synchronisation and lock-lost sticky
    fll_lock_i = 1'b1;
    exp_lock   = 1'b0;
    do_txn(3'd4, 1'b0, 32'h0, rd, er, lat);
    exp_lock   = 1'b1;
    do_txn(3'd4, 1'b0, 32'h0, rd, er, lat);
    chk_b("t5_lock_bit", rd[0], 1'b1);
`ifdef FLL_LOCK_IRQ_EN
    repeat (3) @(posedge clk_i); #1;
    chk_b("t5_irq_idle", irq_o, 1'b0);
    fll_lock_i = 1'b0;
    repeat (4) @(posedge clk_i); #1;
    lost_m   = 1'b1;
    exp_lock = 1'b0;
    chk_b("t5_irq_set", irq_o, 1'b1);
    do_txn(3'd4, 1'b0, 32'h0, rd, er, lat);
    chk_w("t5_status_lost", rd, 32'h4);
    fll_lock_i = 1'b1;
    repeat (4) @(posedge clk_i); #1;
    exp_lock = 1'b1;
    do_txn(3'd4, 1'b1, 32'h4, rd, er, lat);
    chk_b("t5_irq_cleared", irq_o, 1'b0);
    fll_lock_i = 1'b0;
    @(posedge clk_i); #1;
    drop_pending = 1'b1;
    do_txn(3'd4, 1'b1, 32'h6, rd, er, lat);
    drop_pending = 1'b0;
    exp_lock = 1'b0;
    chk_b("t5_set_wins", irq_o, 1'b1);
    do_txn(3'd4, 1'b0, 32'h0, rd, er, lat);
    chk_w("t5_status_after", rd, 32'h4);
`else
    fll_lock_i = 1'b0;
    repeat (4) @(posedge clk_i); #1;
    exp_lock = 1'b0;
    do_txn(3'd4, 1'b1, 32'h4, rd, er, lat);
    do_txn(3'd4, 1'b0, 32'h0, rd, er, lat);
    chk_w("t5_status_no_lost", rd, 32'h0);
`endif

    // 6: asynchronous reset while in REQ
    ack_mode = -1;
    exp_add = 2'd2; exp_wrn = 1'b0; exp_data = 32'h5555_AAAA;
    fll_outstanding = 1'b1;
    PADDR = 12'h008; PWRITE = 1'b1; PWDATA = 32'h5555_AAAA; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk_i); #1;
    PENABLE = 1'b1;
    repeat (4) @(posedge clk_i);
    #3;
    chk_b("t6_req_high", fll_req_o, 1'b1);
    rstn_i = 1'b0;
    #1;
    chk_b("t6_req_async_drop", fll_req_o, 1'b0);
    PSEL = 1'b0; PENABLE = 1'b0;
    fll_outstanding = 1'b0;
    timeout_m = 1'b0;
    lost_m    = 1'b0;
    exp_lock  = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #2 rstn_i = 1'b1;
    @(posedge clk_i); #1;
    ack_mode = 0;
    do_txn(3'd2, 1'b1, 32'h0BAD_F00D, rd, er, lat);
    chk_w("t6_lat", 32'(lat), 32'd4);
    do_txn(3'd2, 1'b0, 32'h0, rd, er, lat);
    chk_w("t6_readback", rd, 32'h0BAD_F00D);
    do_txn(3'd4, 1'b0, 32'h0, rd, er, lat);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
